// File: rtl/div8x4_seq_pkg.sv
// Shared types and constants for the zoom-ratio divider.
package zoom_div_pkg;

    localparam int unsigned DVD_W_DEF = 8;
    localparam int unsigned DSR_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    localparam logic [DVD_W_DEF-1:0] QUO_ONES = '1;

endpackage

// File: rtl/div8x4_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned DSR_W = 4
) (
    input  logic [DSR_W:0]   prem,
    input  logic             dvd_bit,
    input  logic [DSR_W-1:0] divisor,
    output logic [DSR_W:0]   prem_next,
    output logic             q_bit
);

    logic [DSR_W+1:0] p;
    logic [DSR_W+1:0] diff;

    always_comb begin
        p         = {prem, dvd_bit};
        diff      = p - {2'b00, divisor};
        q_bit     = (p >= {2'b00, divisor});
        prem_next = q_bit ? diff[DSR_W:0] : p[DSR_W:0];
    end

endmodule

// File: rtl/div8x4_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional round-to-nearest of the quotient when DIV_ROUND_EN is defined.
module div8x4_seq
    import zoom_div_pkg::*;
#(
    parameter int unsigned DVD_W = DVD_W_DEF,
    parameter int unsigned DSR_W = DSR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DSR_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DSR_W-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned CNT_W = $clog2(DVD_W + 1);

    div_state_t       state_q, state_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DSR_W-1:0] dsr_q, dsr_d;
    logic [DSR_W:0]   prem_q, prem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] quo_q, quo_d;
    logic             dz_q, dz_d;

    logic [DSR_W:0]   step_prem;
    logic             step_qbit;

    div_step #(.DSR_W(DSR_W)) u_step (
        .prem      (prem_q),
        .dvd_bit   (dvd_q[DVD_W-1]),
        .divisor   (dsr_q),
        .prem_next (step_prem),
        .q_bit     (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d  = dividend;
                    dsr_d  = divisor;
                    prem_d = '0;
                    cnt_d  = CNT_W'(DVD_W);
                    if (divisor == '0) begin
                        quo_d   = QUO_ONES;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = '0;
                        dz_d    = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
                prem_d = step_prem;
                quo_d  = {quo_q[DVD_W-2:0], step_qbit};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
`ifdef DIV_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DIV_ROUND_EN
            ROUND: begin
                // Round half up on the truncated remainder; remainder output stays raw.
                if (({prem_q[DSR_W-1:0], 1'b0} >= {1'b0, dsr_q}) && (quo_q != QUO_ONES))
                    quo_d = quo_q + 1'b1;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            dz_q    <= dz_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = prem_q[DSR_W-1:0];
    assign div_zero  = dz_q;

endmodule
